// File: rtl/dds_note_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dds_note_pkg
//  Purpose  : Semitone table, normalisation window and FSM states shared by
//             the note<->DDS increment converters.
//  Revision : 1.0  initial release
// ============================================================================
package dds_note_pkg;

    // Octave index at which TBL entries are used unshifted
    localparam int OCT_TOP = 42;

    localparam logic [31:0] LO = 32'd357872363;
    localparam logic [31:0] HI = 32'd715744726;

    localparam logic [31:0] TBL [12] = '{
        32'd368205249, 32'd390099873, 32'd413296418, 32'd437872302,
        32'd463909544, 32'd491495041, 32'd520720858, 32'd551684531,
        32'd584489400, 32'd619244949, 32'd656067170, 32'd695078954
    };

    // B[k] = floor((TBL[k-1] + TBL[k]) / 2); entry 0 is never used
    localparam logic [31:0] B [12] = '{
        32'd0,         32'd379152561, 32'd401698145, 32'd425584360,
        32'd450890923, 32'd477702292, 32'd506107949, 32'd536202694,
        32'd568086965, 32'd601867174, 32'd637656059, 32'd675573062
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        NORM   = 2'd1,
        SEARCH = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dds2note_norm.sv
`default_nettype none
// ============================================================================
//  Module   : dds2note_norm
//  Purpose  : Holds the working increment N and octave index d, shifting N
//             one bit per step until it lies inside [LO, HI).
//  Revision : 1.0  initial release
// ============================================================================
module dds2note_norm
    import dds_note_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [31:0]        i_load_val,
    input  logic               i_step,
    output logic [31:0]        o_n,
    output logic signed [6:0]  o_d,
    output logic               o_in_win
);

    logic [31:0]       r_n;
    logic signed [6:0] r_d;
    logic              w_above;
    logic              w_below;

    assign w_above  = (r_n >= HI);
    assign w_below  = (r_n < LO);
    assign o_in_win = !w_above && !w_below;
    assign o_n      = r_n;
    assign o_d      = r_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n <= 32'd0;
            r_d <= 7'sd0;
        end else if (i_load) begin
            r_n <= i_load_val;
            r_d <= 7'(OCT_TOP);
        end else if (i_step) begin
            if (w_above) begin
                r_n <= {1'b0, r_n[31:1]};
                r_d <= r_d + 7'sd1;
            end else if (w_below) begin
                r_n <= {r_n[30:0], 1'b0};
                r_d <= r_d - 7'sd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dds2note.sv
`default_nettype none
// ============================================================================
//  Module   : dds2note
//  Purpose  : Converts a 32-bit DDS phase increment to the nearest note number
//             (normalise into one octave, then descending boundary search).
//             Optional macro DDS2NOTE_RESID_EN adds the signed residual output.
//  Revision : 1.0  initial release
// ============================================================================
module dds2note
    import dds_note_pkg::*;
#(
    parameter int NOTE_MAX = 511
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] adder,
    output logic        busy,
    output logic        valid,
    output logic [8:0]  note,
    output logic        err
`ifdef DDS2NOTE_RESID_EN
    ,
    output logic signed [31:0] resid
`endif
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_k;
    logic              r_zero;
    logic              r_busy;
    logic              r_valid;
    logic [8:0]        r_note;
    logic              r_err;

    logic [31:0]       w_n;
    logic signed [6:0] w_d;
    logic              w_in_win;
    logic              w_load;
    logic              w_step;
    logic              w_hit;
    logic [9:0]        w_full;

    assign w_load = (r_state == IDLE) && start;
    assign w_step = (r_state == NORM);

    dds2note_norm u_norm (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (adder),
        .i_step     (w_step),
        .o_n        (w_n),
        .o_d        (w_d),
        .o_in_win   (w_in_win)
    );

    assign w_hit  = (w_n >= B[r_k]);
    // d is never negative for a nonzero increment, so zero-extension is safe
    assign w_full = 10'd12 * {3'b000, w_d} + {6'd0, r_k};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = (adder == 32'd0) ? DONE : NORM;
            NORM:    if (w_in_win) w_state_nxt = SEARCH;
            SEARCH:  if (w_hit || (r_k == 4'd1)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef DDS2NOTE_RESID_EN
    logic signed [31:0] r_resid;
    assign resid = r_resid;
`endif

    // A miss at k==1 decrements to 0, which is itself the final result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k     <= 4'd0;
            r_zero  <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_note  <= 9'd0;
            r_err   <= 1'b0;
`ifdef DDS2NOTE_RESID_EN
            r_resid <= 32'sd0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_zero <= (adder == 32'd0);
                    end
                end
                NORM: begin
                    if (w_in_win) r_k <= 4'd11;
                end
                SEARCH: begin
                    if (!w_hit) r_k <= r_k - 4'd1;
                end
                DONE: begin
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    if (r_zero) begin
                        r_note <= 9'd0;
                        r_err  <= 1'b1;
`ifdef DDS2NOTE_RESID_EN
                        r_resid <= 32'sd0;
`endif
                    end else if (w_full > 10'(NOTE_MAX)) begin
                        r_note <= 9'(NOTE_MAX);
                        r_err  <= 1'b1;
`ifdef DDS2NOTE_RESID_EN
                        r_resid <= 32'sd0;
`endif
                    end else begin
                        r_note <= w_full[8:0];
                        r_err  <= 1'b0;
`ifdef DDS2NOTE_RESID_EN
                        r_resid <= $signed(w_n - TBL[r_k]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = r_busy;
    assign valid = r_valid;
    assign note  = r_note;
    assign err   = r_err;

endmodule
`default_nettype wire
